fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Sequencer that sits in front of `fft_processor`. It collects a frame of `FRAME_LEN` 16-bit audio samples from the upstream source through a valid/ready handshake. It then feeds the frame to the FFT core one sample at a time, allowing for the core's fixed pipeline latency. Each core result is returned downstream as a bin-indexed spectrum word with valid/ready back-pressure.

## Interface
- `FRAME_LEN`, 16: samples per frame; power of two, ≥ 2.
- `FFT_LAT`, 1: core latency in clocks from a `fft_sample` change to the matching `fft_spectrum`; ≥ 1.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous abort of the current frame.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block accepts a sample (combinational from state).
- `in_sample`  in  16  upstream sample.
- `fft_sample`  out  16  registered drive to core `sample`.
- `fft_spectrum`  in  32  core `spectrum` output.
- `out_valid`  out  1  spectrum word valid.
- `out_ready`  in  1  downstream accepts.
- `out_spectrum`  out  32  captured spectrum word.
- `out_bin`  out  $clog2(FRAME_LEN)  bin index of `out_spectrum`.
- `out_last`  out  1  `out_spectrum` is the final bin of the frame.
- `frame_cnt`  out  8  completed frames, wraps 255→0.

## Operation
- States: FILL, LOAD, WAIT, PRESENT.
- FILL:
  - `in_ready`=1.
  - Each `in_valid`&&`in_ready` cycle writes `in_sample` to `buf[wr_idx]`, then `wr_idx`++.
  - The accept at `wr_idx`=FRAME_LEN-1 clears `wr_idx`, clears `rd_idx`, and moves to LOAD.
- LOAD (1 cycle): `fft_sample` <= `buf[rd_idx]`; go to WAIT with `wait_cnt`=FFT_LAT.
- WAIT (FFT_LAT+1 cycles):
  - `wait_cnt` decrements each cycle.
  - On the cycle `wait_cnt`=0: `out_spectrum` <= `fft_spectrum`, `out_bin` <= `rd_idx`, `out_last` <= (`rd_idx`=FRAME_LEN-1); go to PRESENT.
- PRESENT:
  - `out_valid`=1 and all out_* fields stay stable until `out_ready`.
  - On handshake with a non-last bin: `rd_idx`++ and go to LOAD.
  - On handshake with the last bin: `frame_cnt`++ and go to FILL.
- `fft_sample` holds its last value outside LOAD.
- `in_ready`=0 in LOAD, WAIT and PRESENT. Upstream stalls and no sample is dropped.
- `flush`:
  - Highest priority; acts in any state.
  - Next state is FILL; `wr_idx`=`rd_idx`=0; `out_valid` drops the next cycle.
  - `frame_cnt` is unchanged; the partial frame is discarded.
  - A sample offered in the same cycle as `flush` is not written.
- Arithmetic: indices are $clog2(FRAME_LEN) bits and wrap naturally. `frame_cnt` is modulo 256.

## Timing
- Reset values:
  - State: FILL.
  - `in_ready`=1.
  - `fft_sample`=0, `out_valid`=0, `out_spectrum`=0, `out_bin`=0, `out_last`=0.
  - `frame_cnt`=0.
  - Internal indices: 0.
  - Buffer contents: don't-care.
- Reset mid-frame: all partial data is lost, with no output pulse.
- Last sample accepted at edge E: LOAD runs in the cycle after E. `out_valid` rises FFT_LAT+2 cycles after E, which is 3 cycles with the default.
- Per bin, with `out_ready` held high: FFT_LAT+3 cycles.
- Frame throughput: FRAME_LEN input cycles (minimum) plus FRAME_LEN×(FFT_LAT+3) output cycles.
- `in_ready` and `out_valid` never assert in the same cycle.

## Structure
- Package `fft_ctrl_pkg`:
  - `SAMPLE_W`=16, `SPEC_W`=32.
  - State enum `fft_ctrl_state_t` {FILL, LOAD, WAIT, PRESENT}.
- Sub-module `fft_frame_buf`:
  - FRAME_LEN×16 simple dual-port RAM.
  - Synchronous write and asynchronous read (read feeds the LOAD register).
  - No reset.
- Top level contains the FSM, counters and output registers. The bench instantiates it with `fft_processor` connected.

## Test plan
- Reset then 16 samples 0x0001..0x0010 with `in_valid` continuous and `out_ready`=1:
  - 16 outputs, `out_spectrum`=0x0000_0001..0x0000_0010.
  - `out_bin` 0..15, `out_last` only on bin 15.
  - `frame_cnt`=1.
  - First `out_valid` 3 cycles after the 16th accept.
- Stall downstream: hold `out_ready`=0 for 5 cycles on bin 3. `out_valid`, `out_spectrum` and `out_bin`=3 stay stable, and no further LOAD occurs.
- Sparse input: `in_valid` toggles every other cycle. Exactly 16 accepts fill the frame; `in_ready`=0 during output; a sample offered then is held, not lost.
- `flush` asserted in WAIT of bin 7:
  - Next cycle is FILL with `out_valid`=0.
  - `frame_cnt` unchanged.
  - The next 16 samples produce a clean frame with bins 0..15.
- `rst_n` low for 1 cycle mid-fill at `wr_idx`=9: outputs return to reset values immediately, and a full new frame is required.
- 256 back-to-back frames: `frame_cnt` wraps 255→0.

Source files
------------

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and widths for the FFT frame controller.
//   SAMPLE_W          : audio sample width fed to the FFT core
//   SPEC_W            : spectrum word width returned by the FFT core
//   fft_ctrl_state_t  : sequencer states
//     FILL    | collecting FRAME_LEN samples from upstream
//     LOAD    | drive one buffered sample onto the core input
//     WAIT    | let the core pipeline settle, then capture its result
//     PRESENT | hold the captured bin until downstream takes it
package fft_ctrl_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SPEC_W   = 32;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Stream interface of the FFT frame controller.
//   in_*  : upstream sample stream (valid/ready)
//   out_* : downstream spectrum stream (valid/ready) with bin index and
//           end-of-frame marker
// Modports: slave = the controller, master = the source/sink around it.
interface fft_frame_ctrl_if #(
  parameter int FRAME_LEN = 16
);
  import fft_ctrl_pkg::*;

  localparam int BIN_W = $clog2(FRAME_LEN);

  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_sample;

  logic                out_valid;
  logic                out_ready;
  logic [SPEC_W-1:0]   out_spectrum;
  logic [BIN_W-1:0]    out_bin;
  logic                out_last;

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_spectrum, out_bin, out_last
  );

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_spectrum, out_bin, out_last
  );

endinterface

// File: rtl/fft_frame_buf.sv
// Frame sample buffer: DEPTH x WIDTH simple dual-port RAM.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// No reset; contents are only meaningful after a full frame is written.
module fft_frame_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Sequencer in front of the FFT core: buffers a frame of samples, feeds
// them to the core one at a time, waits out the core latency and returns
// each result downstream with its bin index.
//   clk, rst_n   : system clock, async active-low reset
//   flush        : synchronous abort of the current frame
//   bus          : upstream sample / downstream spectrum streams (slave)
//   fft_sample   : registered drive to the core sample input
//   fft_spectrum : core spectrum output
//   frame_cnt    : completed frames, modulo 256
//
// state   | meaning
// FILL    | accept samples into the buffer, in_ready high
// LOAD    | register buf[rd_idx] onto fft_sample
// WAIT    | count down FFT_LAT, capture core result when count hits 0
// PRESENT | out_valid high, hold fields until out_ready
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int FFT_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fft_frame_ctrl_if.slave     bus,
  output logic [SAMPLE_W-1:0] fft_sample,
  input  logic [SPEC_W-1:0]   fft_spectrum,
  output logic [7:0]          frame_cnt
);

  localparam int BIN_W  = $clog2(FRAME_LEN);
  localparam int WAIT_W = (FFT_LAT < 1) ? 1 : $clog2(FFT_LAT + 1);
  localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FRAME_LEN - 1);

  fft_ctrl_state_t     state_q, state_d;
  logic [BIN_W-1:0]    wr_idx_q, wr_idx_d;
  logic [BIN_W-1:0]    rd_idx_q, rd_idx_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SAMPLE_W-1:0] fft_sample_q, fft_sample_d;
  logic [SPEC_W-1:0]   out_spectrum_q, out_spectrum_d;
  logic [BIN_W-1:0]    out_bin_q, out_bin_d;
  logic                out_last_q, out_last_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;

  logic                accept;
  logic [SAMPLE_W-1:0] buf_rdata;

  // A sample offered alongside flush is dropped with the rest of the frame.
  assign accept = (state_q == FILL) && bus.in_valid && !flush;

  fft_frame_buf #(
    .DEPTH (FRAME_LEN),
    .WIDTH (SAMPLE_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_idx_q),
    .wdata (bus.in_sample),
    .raddr (rd_idx_q),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      wait_cnt_q     <= '0;
      fft_sample_q   <= '0;
      out_spectrum_q <= '0;
      out_bin_q      <= '0;
      out_last_q     <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      fft_sample_q   <= fft_sample_d;
      out_spectrum_q <= out_spectrum_d;
      out_bin_q      <= out_bin_d;
      out_last_q     <= out_last_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (bus.in_valid && wr_idx_q == LAST_IDX) state_d = LOAD;
        LOAD:    state_d = WAIT;
        WAIT:    if (wait_cnt_q == '0) state_d = PRESENT;
        PRESENT: if (bus.out_ready) state_d = out_last_q ? FILL : LOAD;
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    wait_cnt_d     = wait_cnt_q;
    fft_sample_d   = fft_sample_q;
    out_spectrum_d = out_spectrum_q;
    out_bin_d      = out_bin_q;
    out_last_d     = out_last_q;
    frame_cnt_d    = frame_cnt_q;
    if (flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (wr_idx_q == LAST_IDX) begin
              wr_idx_d = '0;
              rd_idx_d = '0;
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
        LOAD: begin
          fft_sample_d = buf_rdata;
          wait_cnt_d   = WAIT_W'(FFT_LAT);
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            out_spectrum_d = fft_spectrum;
            out_bin_d      = rd_idx_q;
            out_last_d     = (rd_idx_q == LAST_IDX);
          end else begin
            wait_cnt_d = wait_cnt_q - 1'b1;
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            if (out_last_q) frame_cnt_d = frame_cnt_q + 8'd1;
            else            rd_idx_d    = rd_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode straight from state, so they are mutually exclusive.
  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.out_valid = (state_q == PRESENT);
  end

  assign bus.out_spectrum = out_spectrum_q;
  assign bus.out_bin      = out_bin_q;
  assign bus.out_last     = out_last_q;
  assign fft_sample       = fft_sample_q;
  assign frame_cnt        = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a pass-through stand-in for the
// FFT core (spectrum = zero-extended sample, one clock late).
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int FRAME_LEN = 16;
  localparam int FFT_LAT   = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] fft_sample;
  logic [31:0] fft_spectrum = '0;
  logic [7:0]  frame_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_acc_edge = 0;

  fft_frame_ctrl_if #(.FRAME_LEN(FRAME_LEN)) bus ();

  fft_frame_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .FFT_LAT   (FFT_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .fft_sample   (fft_sample),
    .fft_spectrum (fft_spectrum),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in with a latency of one clock.
  always @(posedge clk) fft_spectrum <= {16'h0000, fft_sample};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Entered and left at 1 ns after a rising edge.
  task automatic push(input logic [15:0] s, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("push_timeout", 32'd0, 32'd1);
    else last_acc_edge = cyc + 1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base, input bit sparse);
    for (int i = 0; i < FRAME_LEN; i++) push(16'(base + i), sparse);
  endtask

  task automatic recv_frame(input logic [15:0] base, input int stall_bin,
                            input int flush_after, input bit chk_lat);
    int t;
    int prev_rise;
    logic [15:0] fs;
    logic [7:0] fc;
    prev_rise = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!bus.out_valid) begin
        chk("rx_timeout", 32'd0, 32'd1);
        return;
      end
      if (chk_lat && i == 0) chk("first_lat", cyc - last_acc_edge, 32'd3);
      if (chk_lat && i == 1) chk("bin_period", cyc - prev_rise, 32'd4);
      prev_rise = cyc;
      chk("spectrum", bus.out_spectrum, {16'h0000, 16'(base + i)});
      chk("bin", 32'(bus.out_bin), i);
      chk("last", 32'(bus.out_last), (i == FRAME_LEN - 1) ? 32'd1 : 32'd0);
      chk("in_ready_out", 32'(bus.in_ready), 32'd0);
      if (i == stall_bin) begin
        bus.out_ready = 1'b0;
        fs = fft_sample;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_spec", bus.out_spectrum, {16'h0000, 16'(base + i)});
          chk("stall_bin", 32'(bus.out_bin), i);
          chk("stall_noload", 32'(fft_sample), 32'(fs));
        end
        bus.out_ready = 1'b1;
      end
      fc = frame_cnt;
      @(posedge clk); #1;
      if (i == flush_after) begin
        // One edge later the next bin sits in WAIT.
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_cnt", 32'(frame_cnt), 32'(fc));
        return;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fft_sample", 32'(fft_sample), 32'd0);
    chk("rst_spectrum", bus.out_spectrum, 32'd0);
    chk("rst_bin", 32'(bus.out_bin), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, samples 1..16.
    fork
      send_frame(16'h0001, 1'b0);
      recv_frame(16'h0001, -1, -1, 1'b1);
    join
    chk("cnt_after_basic", 32'(frame_cnt), 32'd1);

    // Downstream stall on bin 3.
    fork
      send_frame(16'h0100, 1'b0);
      recv_frame(16'h0100, 3, -1, 1'b0);
    join
    chk("cnt_after_stall", 32'(frame_cnt), 32'd2);

    // Sparse input; second frame's first sample waits through the output phase.
    fork
      begin
        send_frame(16'h0200, 1'b1);
        send_frame(16'h0300, 1'b1);
      end
      begin
        recv_frame(16'h0200, -1, -1, 1'b0);
        recv_frame(16'h0300, -1, -1, 1'b0);
      end
    join
    chk("cnt_after_sparse", 32'(frame_cnt), 32'd4);

    // Flush in WAIT of bin 7, then a clean frame.
    fork
      send_frame(16'h0400, 1'b0);
      recv_frame(16'h0400, -1, 6, 1'b0);
    join
    chk("cnt_after_flush", 32'(frame_cnt), 32'd4);
    fork
      send_frame(16'h0500, 1'b0);
      recv_frame(16'h0500, -1, -1, 1'b0);
    join
    chk("cnt_after_clean", 32'(frame_cnt), 32'd5);

    // Reset mid-fill at wr_idx 9.
    for (int i = 0; i < 9; i++) push(16'(16'h0600 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_fft_sample", 32'(fft_sample), 32'd0);
    chk("mid_rst_spectrum", bus.out_spectrum, 32'd0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      send_frame(16'h0700, 1'b0);
      recv_frame(16'h0700, -1, -1, 1'b1);
    join
    chk("cnt_after_rst", 32'(frame_cnt), 32'd1);

    // Back-to-back frames through the 255 -> 0 wrap.
    for (int f = 0; f < 255; f++) begin
      fork
        send_frame(16'(f << 4), 1'b0);
        recv_frame(16'(f << 4), -1, -1, 1'b0);
      join
      if (f == 253) chk("cnt_255", 32'(frame_cnt), 32'd255);
    end
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
